// File: rtl/decode_stage_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, instruction classes,
// control-vector bit positions and fixed write-back registers.
package decode_stage_pkg;

  typedef enum logic [4:0] {
    OP_RTYPE = 5'b00000,
    OP_J     = 5'b00001,
    OP_BNE   = 5'b00010,
    OP_JAL   = 5'b00011,
    OP_JR    = 5'b00100,
    OP_ADDI  = 5'b00101,
    OP_BLT   = 5'b00110,
    OP_SW    = 5'b00111,
    OP_LW    = 5'b01000,
    OP_SETX  = 5'b10101,
    OP_BEX   = 5'b10110
  } opcode_e;

  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_I   = 2'd1,
    CLS_JI  = 2'd2,
    CLS_JII = 2'd3
  } iclass_e;

  localparam int CTRL_W    = 10;
  localparam int CTRL_ALU  = 0;
  localparam int CTRL_SW   = 1;
  localparam int CTRL_LW   = 2;
  localparam int CTRL_BNE  = 3;
  localparam int CTRL_BLT  = 4;
  localparam int CTRL_J    = 5;
  localparam int CTRL_JAL  = 6;
  localparam int CTRL_JR   = 7;
  localparam int CTRL_BEX  = 8;
  localparam int CTRL_SETX = 9;

  localparam logic [4:0] RSTATUS_REG = 5'd30;
  localparam logic [4:0] RA_REG      = 5'd31;

  // Width-independent part of a decoded instruction.
  typedef struct packed {
    logic [4:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        shamt;
    logic [4:0]        aluop;
    iclass_e           iclass;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        wreg;
    logic              we;
    logic              illegal;
  } fields_t;

  function automatic logic [CTRL_W-1:0] ctrl_bit(input int idx);
    return CTRL_W'(1) << idx;
  endfunction

endpackage

// File: rtl/isa_decode.sv
// Purely combinational instruction decoder: field split, immediate and
// target extension, class, one-hot control and write-back target.
module isa_decode
  import decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic [31:0]           insn,
  output fields_t               fields,
  output logic [DATA_WIDTH-1:0] imm,
  output logic [PC_WIDTH-1:0]   target
);

  assign imm    = DATA_WIDTH'($signed(insn[16:0]));
  assign target = PC_WIDTH'(insn[26:0]);

  always_comb begin
    // NOTE: every field gets a default before the case so no path through
    // this block leaves a value unassigned (which would infer a latch).
    fields         = '0;
    fields.opcode  = insn[31:27];
    fields.rd      = insn[26:22];
    fields.rs      = insn[21:17];
    fields.rt      = insn[16:12];
    fields.shamt   = insn[11:7];
    fields.aluop   = insn[6:2];
    case (insn[31:27])
      OP_RTYPE: begin fields.iclass = CLS_R;   fields.ctrl = ctrl_bit(CTRL_ALU);  fields.wreg = insn[26:22]; end
      OP_ADDI:  begin fields.iclass = CLS_I;   fields.ctrl = ctrl_bit(CTRL_ALU);  fields.wreg = insn[26:22]; end
      OP_SW:    begin fields.iclass = CLS_I;   fields.ctrl = ctrl_bit(CTRL_SW);   end
      OP_LW:    begin fields.iclass = CLS_I;   fields.ctrl = ctrl_bit(CTRL_LW);   fields.wreg = insn[26:22]; end
      OP_J:     begin fields.iclass = CLS_JI;  fields.ctrl = ctrl_bit(CTRL_J);    end
      OP_BNE:   begin fields.iclass = CLS_I;   fields.ctrl = ctrl_bit(CTRL_BNE);  end
      OP_JAL:   begin fields.iclass = CLS_JI;  fields.ctrl = ctrl_bit(CTRL_JAL);  fields.wreg = RA_REG; end
      OP_JR:    begin fields.iclass = CLS_JII; fields.ctrl = ctrl_bit(CTRL_JR);   end
      OP_BLT:   begin fields.iclass = CLS_I;   fields.ctrl = ctrl_bit(CTRL_BLT);  end
      OP_BEX:   begin fields.iclass = CLS_JI;  fields.ctrl = ctrl_bit(CTRL_BEX);  end
      OP_SETX:  begin fields.iclass = CLS_JI;  fields.ctrl = ctrl_bit(CTRL_SETX); fields.wreg = RSTATUS_REG; end
      default:  fields.illegal = 1'b1;
    endcase
    // wreg stays 0 for anything without a write-back, so this also covers rd==0.
    fields.we = (fields.wreg != 5'd0);
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: one isa_decode on the incoming instruction feeding a
// main output register and a one-entry skid, so in_ready never depends on out_ready.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_insn,
  input  logic [PC_WIDTH-1:0]   in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [4:0]            out_opcode,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_rs,
  output logic [4:0]            out_rt,
  output logic [4:0]            out_shamt,
  output logic [4:0]            out_aluop,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [PC_WIDTH-1:0]   out_target,
  output logic [1:0]            out_class,
  output logic [9:0]            out_ctrl,
  output logic [4:0]            out_wreg,
  output logic                  out_we,
  output logic                  out_illegal
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] imm;
    logic [PC_WIDTH-1:0]   target;
    fields_t               f;
  } bundle_t;

  bundle_t dec, main_q, skid_q;
  logic    main_valid, skid_valid;
  logic    accept, load_main;

  assign dec.pc = in_pc;

  isa_decode #(
    .DATA_WIDTH(DATA_WIDTH),
    .PC_WIDTH  (PC_WIDTH)
  ) u_isa_decode (
    .insn  (in_insn),
    .fields(dec.f),
    .imm   (dec.imm),
    .target(dec.target)
  );

  assign accept    = in_valid & in_ready;
  // Main frees up when empty or when its bundle is consumed this cycle.
  assign load_main = ~main_valid | out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the data registers are reset too, because every output must read 0
      // out of reset, not only out_valid.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_main) begin
      // NOTE: non-blocking so main and skid both see the pre-edge values when
      // the skid drains into main.
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= accept;
        if (accept) main_q <= dec;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  // skid_valid is a flop, so in_ready has no combinational input path.
  assign in_ready    = ~skid_valid;
  assign out_valid   = main_valid;
  assign out_pc      = main_q.pc;
  assign out_opcode  = main_q.f.opcode;
  assign out_rd      = main_q.f.rd;
  assign out_rs      = main_q.f.rs;
  assign out_rt      = main_q.f.rt;
  assign out_shamt   = main_q.f.shamt;
  assign out_aluop   = main_q.f.aluop;
  assign out_imm     = main_q.imm;
  assign out_target  = main_q.target;
  assign out_class   = main_q.f.iclass;
  assign out_ctrl    = main_q.f.ctrl;
  assign out_wreg    = main_q.f.wreg;
  assign out_we      = main_q.f.we;
  assign out_illegal = main_q.f.illegal;

endmodule
